sharpness_seq: RTL and testbench
================================

Name: sharpness_seq

Overview:
- Sequencer/controller for the sharpness datapath. Runs the per-pixel enable (shp_en), the border/bypass select (shp_sel) and the sharpening mode (spr_sharp_prt).
- Tracks frame and line timing, counts pixels per line, and flushes the 6-deep pipeline at line end by injecting zero-padded cycles.
- Produces an output-valid strobe aligned with shp_out, and exposes line counters and error flags.
- Sits between the SPR input timing front end and the sharpness instance.

Parameters:
- LAT, 6, number of shp_en cycles from a pixel's accept to that pixel's result on shp_out.
- BORDER, 1, pixels at each line edge forced to shp_sel=1 (no valid neighbour diff).
- HW, 12, width of the horizontal pixel counter and cfg_h_active.
- VW, 11, width of the line counter.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- i_vs  in  1  frame-active level; 1 = inside frame.
- i_hs  in  1  line-active level; 1 = inside line.
- i_de  in  1  input pixel valid.
- cfg_sharp_en  in  1  0 = global bypass (shp_sel forced 1).
- cfg_sharp_prt  in  1  mode for the sharpness multiplier truncation.
- cfg_h_active  in  HW  active pixels per line.
- shp_en  out  1  datapath advance enable.
- shp_sel  out  1  zero the neighbour diffs for this cycle.
- spr_sharp_prt  out  1  shadowed cfg_sharp_prt.
- pad_sel  out  1  1 = drive shp_curr/diffs with 0 (flush cycle).
- o_de  out  1  shp_out holds a real pixel's result this cycle.
- line_cnt  out  VW  completed lines in the current frame.
- line_done  out  1  one-cycle pulse when a line's flush completes.
- err_ovf  out  1  sticky: more than cfg_h_active pixels were seen in a line.
- err_abort  out  1  sticky: i_hs fell during ACTIVE or FLUSH.

Behaviour:

Reset (async, rst=1):
- state=IDLE. All outputs and internal registers are 0, including the shadow registers and the token register.

Shadow configuration:
- cfg_sharp_en, cfg_sharp_prt and cfg_h_active are captured on the i_vs rising edge (registered i_vs_d=0, i_vs=1).
- They are constant for the rest of the frame. spr_sharp_prt drives the shadow value.

FSM states: IDLE, WAIT_LINE, ACTIVE, FLUSH, LINE_END.
- IDLE → WAIT_LINE on the i_vs rise. line_cnt is cleared at the same time.
- WAIT_LINE → ACTIVE when i_hs=1 and shadow h_active≠0. pix_cnt is cleared on entry.
- ACTIVE:
  - Each cycle with i_de=1 accepts a pixel: shp_en=1, pix_cnt+1. Cycles with i_de=0 stall: shp_en=0.
  - After accepting pixel index h_active-1, go to FLUSH with flush_cnt=0.
- FLUSH:
  - shp_en=1, pad_sel=1, shp_sel=1 every cycle.
  - i_de is ignored; any i_de=1 here sets err_ovf.
  - After LAT cycles go to LINE_END, pulse line_done and increment line_cnt (saturating at all-ones).
- LINE_END → WAIT_LINE when i_hs=0.
  - i_de=1 in this state sets err_ovf. No shp_en is generated.

shp_sel for accepted pixels:
- 1 if shadow sharp_en=0, or pix_cnt<BORDER, or pix_cnt≥h_active-BORDER.
- If h_active ≤ 2*BORDER, every pixel has shp_sel=1.

Token register and o_de:
- LAT-bit token register; shifts only when shp_en=1. Input bit is 1 for an accepted pixel and 0 for a pad cycle.
- o_de is registered. It is 1 in the cycle after an shp_en cycle whose outgoing tail bit (token[LAT-1] before the shift) is 1; otherwise 0.
- Result: exactly h_active o_de pulses per completed line, in pixel order.

Line and frame aborts (datapath clears on the same conditions):
- i_hs=0 while in ACTIVE or FLUSH:
  - set err_abort;
  - clear the token register; o_de=0 next cycle;
  - go to WAIT_LINE;
  - no line_done, line_cnt unchanged.
- i_vs=0 in any state:
  - go to IDLE; clear the token register, o_de, shp_en and pad_sel;
  - line_cnt is held until the next i_vs rise.
  - err_* flags are sticky; they clear only on rst or the next i_vs rise.

Simultaneous events:
- i_vs fall has priority over i_hs fall, which has priority over an i_de accept.
- The last pixel accepted in the same cycle as i_hs falls counts as aborted.

Outputs: all registered except shp_en and shp_sel, which are decoded from state plus i_de so the datapath sees them in the same cycle as the pixel.

Decomposition:
- Shared package (spr_pkg): FSM state enum; constants SHP_LAT=6 and SHP_BORDER=1; HW/VW width constants.
- One sub-module, shp_token_pipe: the LAT-bit enable-gated shift register with clear, generating o_de.
- The FSM, counters and shadow registers stay in sharpness_seq.

Test Plan:
1. rst, i_vs rise, h_active=8, sharp_en=1, i_hs=1, 8 back-to-back i_de → shp_sel=1,0,0,0,0,0,0,1; 6 pad cycles; o_de pulses 8 times, the first 6 clocks after the first accept; line_done=1; line_cnt=1.
2. Same line with i_de gaps (1 on / 1 off) → shp_en toggles with i_de; o_de count=8 in order; flush still exactly 6 cycles.
3. Change cfg_sharp_prt/cfg_sharp_en mid-frame → spr_sharp_prt/shp_sel unchanged until the next i_vs rise; sharp_en=0 gives shp_sel=1 for every pixel.
4. i_hs falls after 3 of 8 pixels → err_abort=1; no line_done; line_cnt unchanged; o_de=0 from the next cycle; the next line behaves as in scenario 1.
5. 10 i_de pulses with h_active=8 → 8 accepted, err_ovf=1, exactly 8 o_de pulses.
6. Assert rst during FLUSH → all outputs 0 immediately (async); after release, the block waits in IDLE for an i_vs rise.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared constants and FSM state encoding for the sharpness sequencer.
package spr_pkg;

    localparam int unsigned SHP_LAT    = 6;
    localparam int unsigned SHP_BORDER = 1;
    localparam int unsigned HW         = 12;
    localparam int unsigned VW         = 11;
    localparam int unsigned FW         = $clog2(SHP_LAT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_ACTIVE,
        ST_FLUSH,
        ST_LINE_END
    } seq_state_t;

endpackage

// File: rtl/shp_token_pipe.sv
// Enable-gated token shift register tracking which pipeline slots hold real pixels.
module shp_token_pipe
    import spr_pkg::*;
#(
    parameter int unsigned LAT = SHP_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic o_de
);

    logic [LAT-1:0] token;

    // o_de reports the bit leaving the tail on each advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token <= '0;
            o_de  <= 1'b0;
        end else if (clr) begin
            token <= '0;
            o_de  <= 1'b0;
        end else if (en) begin
            o_de  <= token[LAT-1];
            token <= {token[LAT-2:0], din};
        end else begin
            o_de  <= 1'b0;
        end
    end

endmodule

// File: rtl/sharpness_seq.sv
// Sequencer for the sharpness datapath: line/frame timing, pixel counting,
// pipeline flush with pad cycles, output-valid generation and error flags.
module sharpness_seq
    import spr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vs,
    input  logic          i_hs,
    input  logic          i_de,
    input  logic          cfg_sharp_en,
    input  logic          cfg_sharp_prt,
    input  logic [HW-1:0] cfg_h_active,
    output logic          shp_en,
    output logic          shp_sel,
    output logic          spr_sharp_prt,
    output logic          pad_sel,
    output logic          o_de,
    output logic [VW-1:0] line_cnt,
    output logic          line_done,
    output logic          err_ovf,
    output logic          err_abort
);

    seq_state_t    state;
    logic          vs_d;
    logic          sh_en;
    logic [HW-1:0] sh_hact;
    logic [HW-1:0] pix_cnt;
    logic [FW-1:0] flush_cnt;

    logic in_line_c, accept_c, pad_c, border_c, tok_clr_c;

    // Aborts (vs/hs fall) take priority over an accept in the same cycle.
    always_comb begin
        in_line_c = (state == ST_ACTIVE) || (state == ST_FLUSH);
        accept_c  = i_vs && i_hs && (state == ST_ACTIVE) && i_de;
        pad_c     = i_vs && i_hs && (state == ST_FLUSH);
        border_c  = !sh_en
                 || (pix_cnt < HW'(SHP_BORDER))
                 || (pix_cnt >= sh_hact - HW'(SHP_BORDER))
                 || (sh_hact <= HW'(2 * SHP_BORDER));
        tok_clr_c = !i_vs || (in_line_c && !i_hs);
    end

    assign shp_en  = accept_c | pad_c;
    assign shp_sel = pad_c | (accept_c & border_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            vs_d          <= 1'b0;
            sh_en         <= 1'b0;
            spr_sharp_prt <= 1'b0;
            sh_hact       <= '0;
            pix_cnt       <= '0;
            flush_cnt     <= '0;
            pad_sel       <= 1'b0;
            line_cnt      <= '0;
            line_done     <= 1'b0;
            err_ovf       <= 1'b0;
            err_abort     <= 1'b0;
        end else begin
            vs_d      <= i_vs;
            line_done <= 1'b0;
            pad_sel   <= 1'b0;
            if (!i_vs) begin
                state <= ST_IDLE;
            end else if (!vs_d) begin
                // Frame start: shadow the config, restart line count and flags.
                sh_en         <= cfg_sharp_en;
                spr_sharp_prt <= cfg_sharp_prt;
                sh_hact       <= cfg_h_active;
                line_cnt      <= '0;
                err_ovf       <= 1'b0;
                err_abort     <= 1'b0;
                state         <= ST_WAIT_LINE;
            end else begin
                case (state)
                    ST_WAIT_LINE: begin
                        if (i_hs && (sh_hact != '0)) begin
                            pix_cnt <= '0;
                            state   <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!i_hs) begin
                            err_abort <= 1'b1;
                            state     <= ST_WAIT_LINE;
                        end else if (i_de) begin
                            pix_cnt <= pix_cnt + HW'(1);
                            if (pix_cnt == sh_hact - HW'(1)) begin
                                flush_cnt <= '0;
                                pad_sel   <= 1'b1;
                                state     <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (!i_hs) begin
                            err_abort <= 1'b1;
                            state     <= ST_WAIT_LINE;
                        end else begin
                            if (i_de) err_ovf <= 1'b1;
                            flush_cnt <= flush_cnt + FW'(1);
                            if (flush_cnt == FW'(SHP_LAT - 1)) begin
                                line_done <= 1'b1;
                                if (line_cnt != '1) line_cnt <= line_cnt + VW'(1);
                                state <= ST_LINE_END;
                            end else begin
                                pad_sel <= 1'b1;
                            end
                        end
                    end
                    ST_LINE_END: begin
                        if (i_de) err_ovf <= 1'b1;
                        if (!i_hs) state <= ST_WAIT_LINE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    shp_token_pipe #(.LAT(SHP_LAT)) u_token (
        .clk  (clk),
        .rst  (rst),
        .en   (shp_en),
        .clr  (tok_clr_c),
        .din  (accept_c),
        .o_de (o_de)
    );

endmodule

// File: tb/tb_sharpness_seq.sv
// Directed self-checking bench for sharpness_seq.
module tb_sharpness_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vs, i_hs, i_de;
    logic        cfg_sharp_en, cfg_sharp_prt;
    logic [11:0] cfg_h_active;
    logic        shp_en, shp_sel, spr_sharp_prt, pad_sel, o_de;
    logic [10:0] line_cnt;
    logic        line_done, err_ovf, err_abort;

    int n_checks = 0;
    int n_errors = 0;

    sharpness_seq dut (
        .clk           (clk),
        .rst           (rst),
        .i_vs          (i_vs),
        .i_hs          (i_hs),
        .i_de          (i_de),
        .cfg_sharp_en  (cfg_sharp_en),
        .cfg_sharp_prt (cfg_sharp_prt),
        .cfg_h_active  (cfg_h_active),
        .shp_en        (shp_en),
        .shp_sel       (shp_sel),
        .spr_sharp_prt (spr_sharp_prt),
        .pad_sel       (pad_sel),
        .o_de          (o_de),
        .line_cnt      (line_cnt),
        .line_done     (line_done),
        .err_ovf       (err_ovf),
        .err_abort     (err_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic vs, input logic hs, input logic de);
        @(negedge clk);
        i_vs = vs;
        i_hs = hs;
        i_de = de;
        #1;
    endtask

    task automatic new_frame(input logic en, input logic prt, input int hact);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        cfg_sharp_en  = en;
        cfg_sharp_prt = prt;
        cfg_h_active  = 12'(hact);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
    endtask

    // One line from WAIT_LINE: n_de pulses (every other cycle when gap=1),
    // checking shp_sel per accepted pixel, then i_hs drops.
    task automatic run_line(input int n_de, input bit gap, input logic [15:0] sel_exp,
                            output int acc, output int odes, output int pads,
                            output int lat, output int dones);
        int issued = 0;
        int t0 = -1;
        logic de;
        acc = 0; odes = 0; pads = 0; lat = -1; dones = 0;
        drive(1'b1, 1'b1, 1'b0);
        for (int t = 0; t < 40; t++) begin
            de = (issued < n_de) && (!gap || (t % 2 == 0));
            if (de) issued++;
            drive(1'b1, 1'b1, de);
            if (o_de) begin
                odes++;
                if (lat < 0 && t0 >= 0) lat = t - t0;
            end
            if (line_done) dones++;
            if (shp_en && pad_sel) pads++;
            if (shp_en && !pad_sel) begin
                if (t0 < 0) t0 = t;
                if (acc < 16) chk($sformatf("sel_px%0d", acc), int'(shp_sel), int'(sel_exp[acc]));
                acc++;
            end
        end
        drive(1'b1, 1'b0, 1'b0);
    endtask

    int acc, odes, pads, lat, dones;

    initial begin
        rst = 1'b1;
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0;
        cfg_sharp_en = 1'b1; cfg_sharp_prt = 1'b1; cfg_h_active = 12'd8;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_shp_en", int'(shp_en), 0);
        chk("rst_o_de", int'(o_de), 0);
        chk("rst_line_cnt", int'(line_cnt), 0);
        chk("rst_pad_sel", int'(pad_sel), 0);
        chk("rst_prt", int'(spr_sharp_prt), 0);
        chk("rst_errs", int'({err_ovf, err_abort}), 0);
        rst = 1'b0;

        // Frame A, scenario 1: back-to-back line.
        new_frame(1'b1, 1'b1, 8);
        chk("prt_shadow", int'(spr_sharp_prt), 1);
        run_line(8, 1'b0, 16'h0081, acc, odes, pads, lat, dones);
        chk("s1_acc", acc, 8);
        chk("s1_odes", odes, 8);
        chk("s1_pads", pads, 6);
        // o_de rises on the 6th edge after the accepting edge, seen one negedge later.
        chk("s1_lat", lat, 7);
        chk("s1_done", dones, 1);
        chk("s1_line_cnt", int'(line_cnt), 1);

        // Scenario 2: 1-on/1-off pixel gaps.
        run_line(8, 1'b1, 16'h0081, acc, odes, pads, lat, dones);
        chk("s2_acc", acc, 8);
        chk("s2_odes", odes, 8);
        chk("s2_pads", pads, 6);
        chk("s2_line_cnt", int'(line_cnt), 2);

        // Scenario 3: mid-frame config change has no effect until next frame.
        cfg_sharp_en = 1'b0; cfg_sharp_prt = 1'b0;
        run_line(8, 1'b0, 16'h0081, acc, odes, pads, lat, dones);
        chk("s3_prt_held", int'(spr_sharp_prt), 1);
        chk("s3_line_cnt", int'(line_cnt), 3);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("s3_line_cnt_held", int'(line_cnt), 3);

        // Frame B: global bypass, every pixel shp_sel=1.
        new_frame(1'b0, 1'b0, 8);
        chk("s3_prt_new", int'(spr_sharp_prt), 0);
        chk("s3_line_cnt_clr", int'(line_cnt), 0);
        run_line(8, 1'b0, 16'h00FF, acc, odes, pads, lat, dones);
        chk("s3_odes", odes, 8);

        // Frame C, scenario 4: abort after 3 pixels (4th coincides with hs fall).
        new_frame(1'b1, 1'b1, 8);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("s4_abort_no_en", int'(shp_en), 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("s4_err_abort", int'(err_abort), 1);
        odes = 0; dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_de) odes++;
            if (line_done) dones++;
            drive(1'b1, 1'b0, 1'b0);
        end
        chk("s4_no_ode", odes, 0);
        chk("s4_no_done", dones, 0);
        chk("s4_line_cnt", int'(line_cnt), 0);
        run_line(8, 1'b0, 16'h0081, acc, odes, pads, lat, dones);
        chk("s4_next_odes", odes, 8);
        chk("s4_next_line_cnt", int'(line_cnt), 1);
        chk("s4_no_ovf", int'(err_ovf), 0);

        // Scenario 5: 10 pulses into an 8-pixel line.
        run_line(10, 1'b0, 16'h0081, acc, odes, pads, lat, dones);
        chk("s5_acc", acc, 8);
        chk("s5_odes", odes, 8);
        chk("s5_err_ovf", int'(err_ovf), 1);
        chk("s5_line_cnt", int'(line_cnt), 2);

        // Next frame rise clears the sticky flags.
        new_frame(1'b1, 1'b1, 8);
        chk("frame_clr_errs", int'({err_ovf, err_abort}), 0);

        // Scenario 6: async reset in the middle of FLUSH.
        drive(1'b1, 1'b1, 1'b0);
        repeat (8) drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("s6_in_flush", int'(pad_sel), 1);
        rst = 1'b1;
        #1;
        chk("s6_rst_en", int'(shp_en), 0);
        chk("s6_rst_pad", int'(pad_sel), 0);
        chk("s6_rst_sel", int'(shp_sel), 0);
        chk("s6_rst_prt", int'(spr_sharp_prt), 0);
        drive(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        odes = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            if (shp_en) odes++;
        end
        chk("s6_idle_no_en", odes, 0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        run_line(8, 1'b0, 16'h0081, acc, odes, pads, lat, dones);
        chk("s6_after_odes", odes, 8);
        chk("s6_after_line_cnt", int'(line_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
